// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared word width and word type for the datapath blocks
package mycpu_pkg;
   localparam int W = 16;
   typedef logic [W-1:0] word_t;
endpackage

// File: rtl/demuxd_bank_slot.sv
// demuxd_slot: single-entry holding slot; a load wins over a pop so a same-cycle refill never bubbles
module demuxd_slot
   import mycpu_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load,
   input  logic  pop,
   input  word_t d,
   output word_t data,
   output logic  valid
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= d;
         valid <= 1'b1;
      end else if (pop) begin
         valid <= 1'b0;
      end
endmodule

// File: rtl/demuxd_bank.sv
// demuxd_bank: routes one word per cycle into N single-entry channel slots.
// Optional drop counter / sticky error on out-of-range selects: DEMUXD_BANK_ERR_EN.
module demuxd_bank
   import mycpu_pkg::*;
#(
   parameter int N = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   input  logic [$clog2(N)-1:0]  sel_in,
   input  word_t                 d_in,
   output logic                  ready_out,
   output logic [N-1:0]          valid_out,
   output logic [N-1:0][W-1:0]   d_out,
   input  logic [N-1:0]          pop_in
`ifdef DEMUXD_BANK_ERR_EN
   ,
   output logic                  err_out,
   output logic [7:0]            drop_cnt,
   input  logic                  err_clr
`endif
);
   localparam int SW = $clog2(N);
   logic [N-1:0] sel_oh;
   logic         drop;
   // An out-of-range select decodes to no channel, so it is always ready and lands nowhere.
   always_comb begin
      for (int i = 0; i < N; i++) sel_oh[i] = (sel_in == SW'(i));
      ready_out = ~|(sel_oh & valid_out & ~pop_in);
      drop      = valid_in & ~|sel_oh;
   end
   for (genvar g = 0; g < N; g++) begin : g_slot
      demuxd_slot u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (valid_in & ready_out & sel_oh[g]),
         .pop   (pop_in[g]),
         .d     (d_in),
         .data  (d_out[g]),
         .valid (valid_out[g])
      );
   end
`ifdef DEMUXD_BANK_ERR_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         err_out  <= 1'b0;
         drop_cnt <= '0;
      end else if (err_clr) begin
         err_out  <= drop;
         drop_cnt <= {7'd0, drop};
      end else if (drop) begin
         err_out  <= 1'b1;
         drop_cnt <= (drop_cnt == 8'hFF) ? 8'hFF : drop_cnt + 8'd1;
      end
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_demuxd_bank.sv
// tb_demuxd_bank: directed checks of routing, backpressure, discard and async reset (N = 3).
// Error-counter checks are included when DEMUXD_BANK_ERR_EN is defined.
module tb_demuxd_bank;
   logic             clk = 1'b0;
   logic             rst_n;
   logic             valid_in;
   logic [1:0]       sel_in;
   logic [15:0]      d_in;
   logic             ready_out;
   logic [2:0]       valid_out;
   logic [2:0][15:0] d_out;
   logic [2:0]       pop_in;
   int               tests = 0;
   int               fails = 0;
`ifdef DEMUXD_BANK_ERR_EN
   logic             err_out;
   logic [7:0]       drop_cnt;
   logic             err_clr;
`endif

   demuxd_bank #(.N(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .sel_in    (sel_in),
      .d_in      (d_in),
      .ready_out (ready_out),
      .valid_out (valid_out),
      .d_out     (d_out),
      .pop_in    (pop_in)
`ifdef DEMUXD_BANK_ERR_EN
      ,
      .err_out   (err_out),
      .drop_cnt  (drop_cnt),
      .err_clr   (err_clr)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; valid_in = 1'b0; sel_in = '0; d_in = '0; pop_in = '0;
`ifdef DEMUXD_BANK_ERR_EN
      err_clr = 1'b0;
`endif
      #3;
      chk("reset_valid", 64'(valid_out), 64'h0);
      chk("reset_data", 64'(d_out), 64'h0);
`ifdef DEMUXD_BANK_ERR_EN
      chk("reset_err", 64'(err_out), 64'h0);
      chk("reset_cnt", 64'(drop_cnt), 64'h0);
`endif
      tick(); tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      valid_in = 1'b1; sel_in = 2'd1; d_in = 16'hA5A5;
      #1 chk("ready_first", 64'(ready_out), 64'h1);
      tick();
      valid_in = 1'b0;
      chk("first_valid", 64'(valid_out), 64'h2);
      chk("first_data", 64'(d_out[1]), 64'hA5A5);
      pop_in = 3'b010;
      tick();
      pop_in = 3'b000;
      chk("pop_clear", 64'(valid_out), 64'h0);
      chk("pop_hold_data", 64'(d_out[1]), 64'hA5A5);

      valid_in = 1'b1; sel_in = 2'd0; d_in = 16'h1111;
      tick();
      d_in = 16'h2222;
      #1 chk("stall_ready", 64'(ready_out), 64'h0);
      tick();
      chk("stall_data", 64'(d_out[0]), 64'h1111);
      chk("stall_valid", 64'(valid_out), 64'h1);
      pop_in = 3'b001;
      #1 chk("pop_ready", 64'(ready_out), 64'h1);
      tick();
      valid_in = 1'b0; pop_in = 3'b000;
      chk("refill_data", 64'(d_out[0]), 64'h2222);
      chk("refill_valid", 64'(valid_out), 64'h1);

      pop_in = 3'b100;
      tick();
      chk("pop_empty_ignored", 64'(valid_out), 64'h1);
      pop_in = 3'b001;
      tick();
      pop_in = 3'b000;
      chk("drain0", 64'(valid_out), 64'h0);

      valid_in = 1'b1; sel_in = 2'd0; d_in = 16'h0001;
      #1 chk("b2b_ready0", 64'(ready_out), 64'h1);
      tick();
      sel_in = 2'd1; d_in = 16'h0002;
      #1 chk("b2b_ready1", 64'(ready_out), 64'h1);
      tick();
      sel_in = 2'd2; d_in = 16'h0003;
      #1 chk("b2b_ready2", 64'(ready_out), 64'h1);
      tick();
      valid_in = 1'b0;
      chk("b2b_valid", 64'(valid_out), 64'h7);
      chk("b2b_data", 64'(d_out), 64'h0003_0002_0001);
      valid_in = 1'b1; sel_in = 2'd1; d_in = 16'h7777;
      #1 chk("full1_ready", 64'(ready_out), 64'h0);
      tick();
      chk("full1_hold", 64'(d_out[1]), 64'h0002);

      sel_in = 2'd3; d_in = 16'hDEAD;
      #1 chk("oor_ready", 64'(ready_out), 64'h1);
      tick();
      chk("oor_valid", 64'(valid_out), 64'h7);
      chk("oor_data", 64'(d_out), 64'h0003_0002_0001);
`ifdef DEMUXD_BANK_ERR_EN
      chk("oor_err", 64'(err_out), 64'h1);
      chk("oor_cnt1", 64'(drop_cnt), 64'h1);
      for (int i = 0; i < 299; i++) tick();
      chk("oor_cnt_sat", 64'(drop_cnt), 64'hFF);
      err_clr = 1'b1;
      tick();
      chk("clr_drop_err", 64'(err_out), 64'h1);
      chk("clr_drop_cnt", 64'(drop_cnt), 64'h1);
      valid_in = 1'b0;
      tick();
      err_clr = 1'b0;
      chk("clr_err", 64'(err_out), 64'h0);
      chk("clr_cnt", 64'(drop_cnt), 64'h0);
`endif
      valid_in = 1'b0;

      pop_in = 3'b010;
      tick();
      pop_in = 3'b000;
      chk("pre_rst_valid", 64'(valid_out), 64'h5);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_valid", 64'(valid_out), 64'h0);
      chk("async_rst_data", 64'(d_out), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      valid_in = 1'b1; sel_in = 2'd2; d_in = 16'hBEEF;
      #1 chk("post_rst_ready", 64'(ready_out), 64'h1);
      tick();
      valid_in = 1'b0;
      chk("post_rst_valid", 64'(valid_out), 64'h4);
      chk("post_rst_data", 64'(d_out[2]), 64'hBEEF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/demuxd_bank.md
DEMUXD_BANK -- requirements
Module: demuxd_bank

Interface
REQ-001 SHALL have parameter: N, default 3, number of destination channels (N >= 2).
REQ-002 SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: valid_in  input  1  producer offers a word this cycle.
REQ-005 SHALL have port: sel_in  input  $clog2(N)  destination channel index.
REQ-006 SHALL have port: d_in  input  16  word to route.
REQ-007 SHALL have port: ready_out  output  1  the word on d_in is accepted this cycle.
REQ-008 SHALL have port: valid_out  output  N  per-channel holding-slot full flag.
REQ-009 SHALL have port: d_out  output  N x 16  per-channel held word, packed as [N-1:0][15:0].
REQ-010 SHALL have port: pop_in  input  N  per-channel consumer takes its word this cycle.

Function
REQ-011 SHALL implement one single-entry holding slot per channel; a handshake is valid_in && ready_out.
REQ-012 SHALL drive ready_out = 1 when sel_in >= N, or when valid_out[sel_in] = 0 or pop_in[sel_in] = 1; ready_out is combinational.
REQ-013 SHALL, on a handshake with sel_in < N, load d_in into slot sel_in and set valid_out[sel_in] on the next edge (1-cycle latency).
REQ-014 SHALL, on pop_in[i] && valid_out[i] with no load to slot i, clear valid_out[i] on the next edge; d_out[i] holds its last value.
REQ-015 SHALL, on a simultaneous pop and load to the same slot, take the new word and keep valid_out[i] = 1 (no bubble).
REQ-016 SHALL ignore pop_in[i] when valid_out[i] = 0.
REQ-017 SHALL leave every slot other than sel_in unchanged by a load.
REQ-018 SHALL hold d_in stalled (no state change) when valid_in = 1 and ready_out = 0; the producer keeps sel_in/d_in stable.
REQ-019 SHALL, on a handshake with sel_in >= N, discard the word and change no slot.

Reset
REQ-020 SHALL, while rst_n = 0, force valid_out = 0 and every d_out word = 16'h0000, independent of clk.
REQ-021 SHALL, on reset asserted mid-transfer, drop all held and in-flight words; the first handshake after release is accepted normally.

Configuration
REQ-022 SHALL recognise macro DEMUXD_BANK_ERR_EN.
REQ-023 SHALL, with DEMUXD_BANK_ERR_EN defined, add ports err_out (output, 1), drop_cnt (output, 8) and err_clr (input, 1).
REQ-024 SHALL, with DEMUXD_BANK_ERR_EN defined, set err_out sticky and increment drop_cnt (saturating at 8'hFF) on each discarded handshake with sel_in >= N.
REQ-025 SHALL, with DEMUXD_BANK_ERR_EN defined, clear err_out and drop_cnt on err_clr = 1; a simultaneous discard during err_clr leaves err_out = 1 and drop_cnt = 1; both reset to 0.
REQ-026 SHALL, without DEMUXD_BANK_ERR_EN, omit these ports and silently discard out-of-range words.

Structure
REQ-027 SHALL take the 16-bit word width and the word_t typedef from mycpu_pkg; no local width literals.
REQ-028 SHALL instantiate sub-module demuxd_slot N times; each slot has load, pop, data and valid, and the top holds only select decode, ready logic and the error feature.

Verification
REQ-029 SHALL cover: reset, then valid_in = 1, sel_in = 1, d_in = 16'hA5A5 -> ready_out = 1; next cycle valid_out = 3'b010, d_out[1] = 16'hA5A5.
REQ-030 SHALL cover: slot 0 full with 16'h1111, new word 16'h2222 to sel 0, pop_in = 0 -> ready_out = 0, slot holds 16'h1111; raise pop_in[0] -> accepted, next cycle d_out[0] = 16'h2222, valid_out[0] = 1.
REQ-031 SHALL cover: back-to-back words 16'h0001, 16'h0002, 16'h0003 to sel 0, 1, 2 in three cycles -> all accepted, valid_out = 3'b111 with the matching data.
REQ-032 SHALL cover: N = 3, sel_in = 3, d_in = 16'hDEAD -> ready_out = 1, no valid_out change; with DEMUXD_BANK_ERR_EN, err_out = 1 and drop_cnt = 1; after 300 such words, drop_cnt = 8'hFF.
REQ-033 SHALL cover: rst_n pulsed low asynchronously, between edges, with valid_out = 3'b101 -> valid_out = 0 and d_out = 0 immediately, before the next clk edge.
